// File: rtl/tx_block_if.sv
// tx_block_if -- byte-write and serial-line bundle for the UART transmitter.
//
// Signals:
//   tx_data       byte to transmit, sampled when a write is accepted
//   data_write    one-cycle write strobe (the "valid" of the write handshake)
//   serial_out    UART line, idle high
//   tx_empty      holding buffer empty (the "ready" of the write handshake)
//   busy          a frame is being shifted out
//   tx_done       one-cycle pulse after the stop bit completes
//   overrun_error one-cycle pulse when a write is dropped
//   state_dbg     current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
//
// Handshake: a write transfers on a rising edge where data_write=1 and
// tx_empty=1. data_write is a strobe, not a held request: if tx_empty=0 at
// that edge the byte is dropped (never retried) and overrun_error pulses
// in the following cycle.
interface tx_block_if;
  logic [7:0] tx_data;
  logic       data_write;
  logic       serial_out;
  logic       tx_empty;
  logic       busy;
  logic       tx_done;
  logic       overrun_error;
  logic [1:0] state_dbg;

  modport master (
    output tx_data, data_write,
    input  serial_out, tx_empty, busy, tx_done, overrun_error, state_dbg
  );

  modport slave (
    input  tx_data, data_write,
    output serial_out, tx_empty, busy, tx_done, overrun_error, state_dbg
  );
endinterface

// File: rtl/tx_block.sv
// tx_block -- UART transmitter with a one-byte holding buffer.
//
// Sends 8N1 frames (start 0, data LSB first, stop 1), each bit lasting
// BIT_PERIOD clock cycles. A new byte may be written while a frame is in
// progress; it is sent back-to-back after the current stop bit.
//
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous reset, active high (1 = in reset)
//   bus    tx_block_if.slave: tx_data/data_write in; serial_out, tx_empty,
//          busy, tx_done, overrun_error, state_dbg out
//
// Every output is a flop. serial_out is computed from the current state, so
// the line lags the FSM by one cycle: a write at edge k loads the shift
// register at k+1 and the start bit appears at k+2.
module tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic        clk,
  input  logic        n_rst,
  tx_block_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] LAST_TICK = 8'(BIT_PERIOD - 1);

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] buf_q, buf_d;
  logic       full_q, full_d;
  logic       ser_q, ser_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;

  logic       bit_end;
  logic [7:0] timer_inc;

  assign bit_end   = (timer_q == LAST_TICK);
  assign timer_inc = bit_end ? 8'd0 : timer_q + 8'd1;

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      buf_q   <= '0;
      full_q  <= 1'b0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      buf_q   <= buf_d;
      full_q  <= full_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    buf_d   = buf_q;
    full_d  = full_q;
    ser_d   = 1'b1;
    done_d  = 1'b0;
    ovr_d   = bus.data_write & full_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (full_q) begin
          state_d = START;
          shreg_d = buf_q;
          full_d  = 1'b0;
        end
      end
      START: begin
        ser_d   = 1'b0;
        timer_d = timer_inc;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        ser_d   = shreg_q[0];
        timer_d = timer_inc;
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        ser_d   = 1'b1;
        timer_d = timer_inc;
        if (bit_end) begin
          done_d = 1'b1;
          // A byte already waiting goes straight out; a byte written at
          // this very edge is only seen next cycle, giving one IDLE cycle.
          if (full_q) begin
            state_d = START;
            shreg_d = buf_q;
            full_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept needs an empty buffer, a load needs a full one, so the two
    // never collide on the same edge.
    if (bus.data_write && !full_q) begin
      full_d = 1'b1;
      buf_d  = bus.tx_data;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.serial_out    = ser_q;
  assign bus.tx_empty      = ~full_q;
  assign bus.busy          = busy_q;
  assign bus.tx_done       = done_q;
  assign bus.overrun_error = ovr_q;
  assign bus.state_dbg     = state_q;

endmodule
